// File: rtl/can_frame_sequencer_if.sv
// Signal bundle between the bit-timing/de-stuff stage and the CAN frame-field sequencer.
// The sequencer is the slave; the bit stream source and field consumers form the master side.
interface can_frame_sequencer_if;
  logic       sample_point_i;
  logic       sampled_bit_i;
  logic       bit_de_stuff_i;
  logic       fd_enable_i;
  logic       iso_mode_i;
  logic       reset_mode_i;
  logic       node_bus_off_i;
  logic       err_condition_i;
  logic       overload_condition_i;
  logic       error_frame_ended_i;
  logic       overload_frame_ended_i;

  logic [4:0] state_o;
  logic       field_start_o;
  logic       frame_done_o;
  logic [8:0] bit_cnt_o;
  logic       ide_o;
  logic       rtr_o;
  logic       edl_o;
  logic       brs_o;
  logic       esi_o;
  logic [3:0] dlc_o;
  logic [6:0] data_len_o;
  logic [4:0] crc_len_o;
  logic       bus_idle_o;

  modport slave (
    input  sample_point_i, sampled_bit_i, bit_de_stuff_i, fd_enable_i, iso_mode_i,
           reset_mode_i, node_bus_off_i, err_condition_i, overload_condition_i,
           error_frame_ended_i, overload_frame_ended_i,
    output state_o, field_start_o, frame_done_o, bit_cnt_o, ide_o, rtr_o, edl_o,
           brs_o, esi_o, dlc_o, data_len_o, crc_len_o, bus_idle_o
  );

  modport master (
    output sample_point_i, sampled_bit_i, bit_de_stuff_i, fd_enable_i, iso_mode_i,
           reset_mode_i, node_bus_off_i, err_condition_i, overload_condition_i,
           error_frame_ended_i, overload_frame_ended_i,
    input  state_o, field_start_o, frame_done_o, bit_cnt_o, ide_o, rtr_o, edl_o,
           brs_o, esi_o, dlc_o, data_len_o, crc_len_o, bus_idle_o
  );
endinterface

// File: rtl/can_frame_sequencer.sv
// Receive-path CAN / CAN FD frame-field sequencer: owns the field bit counter,
// header flag capture and DLC-to-length decode; all outputs registered.
module can_frame_sequencer #(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter bit          SUPPORT_FD     = 1'b1,
  parameter int unsigned ACK_FD_BITS    = 2,
  parameter int unsigned EOF_BITS       = 7,
  parameter int unsigned INTER_BITS     = 3,
  parameter int unsigned IDLE_BITS      = 11
) (
  input logic                  clk_i,
  input logic                  rst_i,
  can_frame_sequencer_if.slave bus
);

  typedef enum logic [4:0] {
    ST_OFF         = 5'd0,
    ST_INTEGRATING = 5'd1,
    ST_BUS_IDLE    = 5'd2,
    ST_ID_1        = 5'd3,
    ST_RTR_1       = 5'd4,
    ST_IDE         = 5'd5,
    ST_ID_2        = 5'd6,
    ST_RTR_2       = 5'd7,
    ST_FDF         = 5'd8,
    ST_R0          = 5'd9,
    ST_RES         = 5'd10,
    ST_BRS         = 5'd11,
    ST_ESI         = 5'd12,
    ST_DLC         = 5'd13,
    ST_DATA        = 5'd14,
    ST_STUFF_COUNT = 5'd15,
    ST_CRC         = 5'd16,
    ST_CRC_LIM     = 5'd17,
    ST_ACK         = 5'd18,
    ST_ACK_LIM     = 5'd19,
    ST_EOF         = 5'd20,
    ST_INTER       = 5'd21,
    ST_ERROR       = 5'd22,
    ST_OVERLOAD    = 5'd23
  } state_e;

  localparam logic [9:0] ACK_FD_LEN = 10'(ACK_FD_BITS);
  localparam logic [9:0] EOF_LEN    = 10'(EOF_BITS);
  localparam logic [9:0] INTER_LEN  = 10'(INTER_BITS);
  localparam logic [9:0] IDLE_LEN   = 10'(IDLE_BITS);
  localparam logic [6:0] MAX_LEN    = 7'(MAX_DATA_BYTES);

  function automatic logic [6:0] dlc_decode(input logic [3:0] dlc, input logic fd);
    logic [6:0] len;
    if (dlc <= 4'd8) begin
      len = {3'b000, dlc};
    end else if (!fd) begin
      len = 7'd8;
    end else begin
      case (dlc)
        4'd9:    len = 7'd12;
        4'd10:   len = 7'd16;
        4'd11:   len = 7'd20;
        4'd12:   len = 7'd24;
        4'd13:   len = 7'd32;
        4'd14:   len = 7'd48;
        default: len = 7'd64;
      endcase
    end
    if (len > MAX_LEN) len = MAX_LEN;
    return len;
  endfunction

  function automatic logic [4:0] crc_length(input logic fd, input logic [6:0] len);
    if (!fd)               return 5'd15;
    else if (len <= 7'd16) return 5'd17;
    else                   return 5'd21;
  endfunction

  state_e     state_q, state_d;
  logic [8:0] bit_cnt_q, bit_cnt_d;
  logic       ide_q, ide_d, rtr_q, rtr_d, edl_q, edl_d, brs_q, brs_d, esi_q, esi_d;
  logic [3:0] dlc_q, dlc_d;
  logic [6:0] data_len_q, data_len_d;
  logic [4:0] crc_len_q, crc_len_d;
  logic       field_start_q, field_start_d;
  logic       frame_done_q, frame_done_d;
  logic       bus_idle_q, bus_idle_d;

  logic       vb, adv, smp_bit, last, force_off;
  logic [9:0] cnt_p1, field_len;
  state_e     post_data;

  always_comb begin
    smp_bit   = bus.sampled_bit_i;
    vb        = bus.sample_point_i & ~bus.bit_de_stuff_i;
    force_off = bus.reset_mode_i | bus.node_bus_off_i;
    // Stuff bits only exist inside the arbitration/control/data/CRC fields.
    adv       = (state_q >= ST_ACK || state_q <= ST_BUS_IDLE) ? bus.sample_point_i : vb;
    cnt_p1    = {1'b0, bit_cnt_q} + 10'd1;
    post_data = (edl_q & bus.iso_mode_i) ? ST_STUFF_COUNT : ST_CRC;

    case (state_q)
      ST_INTEGRATING: field_len = IDLE_LEN;
      ST_ID_1:        field_len = 10'd11;
      ST_ID_2:        field_len = 10'd18;
      ST_DLC:         field_len = 10'd4;
      ST_DATA:        field_len = {data_len_q, 3'b000};
      ST_STUFF_COUNT: field_len = 10'd4;
      ST_CRC:         field_len = {5'd0, crc_len_q};
      ST_ACK:         field_len = edl_q ? ACK_FD_LEN : 10'd1;
      ST_EOF:         field_len = EOF_LEN;
      ST_INTER:       field_len = INTER_LEN;
      default:        field_len = 10'd1;
    endcase
    last = adv && (cnt_p1 == field_len);

    state_d = state_q;
    ide_d   = ide_q;
    rtr_d   = rtr_q;
    edl_d   = edl_q;
    brs_d   = brs_q;
    esi_d   = esi_q;
    dlc_d   = dlc_q;

    case (state_q)
      ST_OFF:         state_d = ST_INTEGRATING;
      ST_INTEGRATING: if (last && smp_bit) state_d = ST_BUS_IDLE;
      ST_BUS_IDLE:    if (adv && !smp_bit) state_d = ST_ID_1;
      ST_ID_1:        if (last) state_d = ST_RTR_1;
      ST_RTR_1: if (last) begin
        rtr_d   = smp_bit;
        state_d = ST_IDE;
      end
      ST_IDE: if (last) begin
        ide_d   = smp_bit;
        state_d = smp_bit ? ST_ID_2 : ST_FDF;
      end
      ST_ID_2: if (last) state_d = ST_RTR_2;
      ST_RTR_2: if (last) begin
        rtr_d   = smp_bit;
        state_d = ST_FDF;
      end
      ST_FDF: if (last) begin
        if (!smp_bit) begin
          edl_d   = 1'b0;
          state_d = ide_q ? ST_R0 : ST_DLC;
        end else if (SUPPORT_FD && bus.fd_enable_i) begin
          edl_d   = 1'b1;
          rtr_d   = 1'b0;
          state_d = ST_RES;
        end else begin
          // FD-tolerant: drop the frame silently and re-integrate.
          state_d = ST_INTEGRATING;
        end
      end
      ST_R0:  if (last) state_d = ST_DLC;
      ST_RES: if (last) state_d = ST_BRS;
      ST_BRS: if (last) begin
        brs_d   = smp_bit;
        state_d = ST_ESI;
      end
      ST_ESI: if (last) begin
        esi_d   = smp_bit;
        state_d = ST_DLC;
      end
      ST_DLC: begin
        if (adv) dlc_d = {dlc_q[2:0], smp_bit};
        if (last) begin
          if (dlc_decode(dlc_d, edl_q) == 7'd0 || (rtr_q && !edl_q)) state_d = post_data;
          else                                                        state_d = ST_DATA;
        end
      end
      ST_DATA:        if (last) state_d = post_data;
      ST_STUFF_COUNT: if (last) state_d = ST_CRC;
      ST_CRC:         if (last) state_d = ST_CRC_LIM;
      ST_CRC_LIM:     if (last) state_d = ST_ACK;
      ST_ACK:         if (last) state_d = ST_ACK_LIM;
      ST_ACK_LIM:     if (last) state_d = ST_EOF;
      ST_EOF: begin
        if (bus.overload_condition_i) state_d = ST_OVERLOAD;
        else if (last)                state_d = ST_INTER;
      end
      ST_INTER: begin
        if (bus.overload_condition_i) state_d = ST_OVERLOAD;
        else if (last)                state_d = smp_bit ? ST_BUS_IDLE : ST_ID_1;
      end
      ST_ERROR: begin
        if (bus.error_frame_ended_i)       state_d = ST_INTER;
        else if (bus.overload_condition_i) state_d = ST_OVERLOAD;
      end
      ST_OVERLOAD: if (bus.overload_frame_ended_i) state_d = ST_INTER;
      default: state_d = ST_OFF;
    endcase

    if (bus.err_condition_i && state_q != ST_OFF && state_q != ST_INTEGRATING &&
        state_q != ST_ERROR && state_q != ST_OVERLOAD) begin
      state_d = ST_ERROR;
    end
    if (force_off) state_d = ST_OFF;

    // SOF: header captures from the previous frame are discarded.
    if (state_d == ST_ID_1 && state_q != ST_ID_1) begin
      ide_d = 1'b0;
      rtr_d = 1'b0;
      edl_d = 1'b0;
      brs_d = 1'b0;
      esi_d = 1'b0;
      dlc_d = 4'd0;
    end

    data_len_d = dlc_decode(dlc_d, edl_d);
    crc_len_d  = crc_length(edl_d, data_len_d);

    if (state_d != state_q) begin
      bit_cnt_d = 9'd0;
    end else if (state_q == ST_INTEGRATING && adv && !smp_bit) begin
      bit_cnt_d = 9'd0;
    end else if (adv && state_q != ST_OFF && bit_cnt_q != 9'd511) begin
      bit_cnt_d = bit_cnt_q + 9'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    field_start_d = (state_d != state_q);
    frame_done_d  = (state_q == ST_EOF) && (state_d == ST_INTER);
    bus_idle_d    = (state_d == ST_BUS_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_OFF;
      bit_cnt_q     <= 9'd0;
      ide_q         <= 1'b0;
      rtr_q         <= 1'b0;
      edl_q         <= 1'b0;
      brs_q         <= 1'b0;
      esi_q         <= 1'b0;
      dlc_q         <= 4'd0;
      data_len_q    <= 7'd0;
      crc_len_q     <= 5'd15;
      field_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      bus_idle_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ide_q         <= ide_d;
      rtr_q         <= rtr_d;
      edl_q         <= edl_d;
      brs_q         <= brs_d;
      esi_q         <= esi_d;
      dlc_q         <= dlc_d;
      data_len_q    <= data_len_d;
      crc_len_q     <= crc_len_d;
      field_start_q <= field_start_d;
      frame_done_q  <= frame_done_d;
      bus_idle_q    <= bus_idle_d;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.field_start_o = field_start_q;
  assign bus.frame_done_o  = frame_done_q;
  assign bus.bit_cnt_o     = bit_cnt_q;
  assign bus.ide_o         = ide_q;
  assign bus.rtr_o         = rtr_q;
  assign bus.edl_o         = edl_q;
  assign bus.brs_o         = brs_q;
  assign bus.esi_o         = esi_q;
  assign bus.dlc_o         = dlc_q;
  assign bus.data_len_o    = data_len_q;
  assign bus.crc_len_o     = crc_len_q;
  assign bus.bus_idle_o    = bus_idle_q;

endmodule
